// File: rtl/wb_ram_slave.sv
// Single-port word RAM on the strobe/acknowledge bus with programmable wait
// states; ack_o is held until the initiator releases stb_i.
module wb_ram_slave #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] dat_o,
  output logic        ack_o
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam logic [32:0] SPAN    = 33'(DEPTH) << 2;
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  logic [31:0] cap_adr, cap_dat;
  logic        cap_we;
  logic [3:0]  cap_sel;

  logic        access;
  logic [31:0] acc_adr, acc_dat;
  logic        acc_we;
  logic [3:0]  acc_sel;

  logic [31:0]      off;
  logic             hit;
  logic [IDX_W-1:0] idx;
  logic             unused_lsb;

  logic [31:0] mem [DEPTH];

  // With no wait states the access happens on the accept edge itself, so it
  // must use the live bus rather than the captured copy.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    acc_adr   = cap_adr;
    acc_dat   = cap_dat;
    acc_we    = cap_we;
    acc_sel   = cap_sel;
    case (state)
      S_IDLE: begin
        if (stb_i) begin
          acc_adr = adr_i;
          acc_dat = dat_i;
          acc_we  = we_i;
          acc_sel = sel_i;
          if (WAIT_STATES == 0) begin
            state_nxt = S_ACK;
            access    = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!stb_i) begin
          state_nxt = S_IDLE;
        end else if (cnt == '0) begin
          state_nxt = S_ACK;
          access    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_ACK: begin
        if (!stb_i) state_nxt = S_RELEASE;
      end
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign off        = acc_adr - BASE;
  assign hit        = {1'b0, off} < SPAN;
  assign idx        = off[IDX_W+1:2];
  assign unused_lsb = ^off[1:0];

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack_o <= (state_nxt == S_ACK);
      if (access && !acc_we) dat_o <= hit ? mem[idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && stb_i) begin
      cap_adr <= adr_i;
      cap_dat <= dat_i;
      cap_we  <= we_i;
      cap_sel <= sel_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_i && access && acc_we && hit) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (acc_sel[k]) mem[idx][8*k +: 8] <= acc_dat[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench: DUT 0 has two wait states, DUT 1 has none.
module tb_wb_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb  [2];
  logic        we   [2];
  logic [31:0] adr  [2];
  logic [31:0] dat  [2];
  logic [3:0]  sel  [2];
  logic [31:0] rdat [2];
  logic        ack  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_ram_slave #(.DEPTH(1024), .BASE(32'h0), .WAIT_STATES(2), .INIT_FILE("")) u_ws2 (
    .clk(clk), .rst_i(rst), .stb_i(stb[0]), .we_i(we[0]), .adr_i(adr[0]),
    .dat_i(dat[0]), .sel_i(sel[0]), .dat_o(rdat[0]), .ack_o(ack[0])
  );

  wb_ram_slave #(.DEPTH(1024), .BASE(32'h0), .WAIT_STATES(0), .INIT_FILE("")) u_ws0 (
    .clk(clk), .rst_i(rst), .stb_i(stb[1]), .we_i(we[1]), .adr_i(adr[1]),
    .dat_i(dat[1]), .sel_i(sel[1]), .dat_o(rdat[1]), .ack_o(ack[1])
  );

  typedef struct {
    int          d;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  s;
    int          hold;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input logic ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] s, input int hold, input logic chk,
                     input logic [31:0] exp, input int id);
    int          n;
    int          lat;
    logic [31:0] held;
    lat = (d == 0) ? 2 : 0;
    @(posedge clk); #1;
    stb[d] = 1'b1; we[d] = w; adr[d] = a; dat[d] = wd; sel[d] = s;
    @(posedge clk); #1;
    // Scramble the bus after the accept edge; the DUT must use its captured copy.
    we[d] = ~w; adr[d] = ~a; dat[d] = ~wd; sel[d] = ~s;
    n = 0;
    while (!ack[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(n == lat, $sformatf("ack_latency[%0d]", id), 32'(n), 32'(lat));
    held = rdat[d];
    if (chk) check(held == exp, $sformatf("read_data[%0d]", id), held, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check(ack[d] === 1'b1 && rdat[d] === held, $sformatf("hold[%0d.%0d]", id, i),
            rdat[d], held);
    end
    stb[d] = 1'b0;
    @(posedge clk); #1;
    check(ack[d] === 1'b0, $sformatf("ack_fall[%0d]", id), 32'(ack[d]), 32'd0);
  endtask

  initial begin
    int   n;
    logic ok;

    vecs[0]  = '{0, 1'b1, 32'h10,   32'hCAFE_F00D, 4'hF, 0, 1'b0, 32'h0};
    vecs[1]  = '{0, 1'b0, 32'h10,   32'h0,         4'hF, 1, 1'b1, 32'hCAFE_F00D};
    vecs[2]  = '{0, 1'b1, 32'h14,   32'h1122_3344, 4'hF, 0, 1'b0, 32'h0};
    vecs[3]  = '{0, 1'b1, 32'h14,   32'hAAAA_AAAA, 4'h5, 0, 1'b0, 32'h0};
    vecs[4]  = '{0, 1'b0, 32'h14,   32'h0,         4'hF, 0, 1'b1, 32'h11AA_33AA};
    vecs[5]  = '{0, 1'b0, 32'h10,   32'h0,         4'h0, 0, 1'b1, 32'hCAFE_F00D};
    vecs[6]  = '{0, 1'b1, 32'h0,    32'h0BAD_F00D, 4'hF, 0, 1'b0, 32'h0};
    vecs[7]  = '{0, 1'b1, 32'hFFC,  32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0};
    vecs[8]  = '{0, 1'b1, 32'h1000, 32'h1234_5678, 4'hF, 0, 1'b0, 32'h0};
    vecs[9]  = '{0, 1'b0, 32'h1000, 32'h0,         4'hF, 0, 1'b1, 32'h0};
    vecs[10] = '{0, 1'b0, 32'h0,    32'h0,         4'hF, 0, 1'b1, 32'h0BAD_F00D};
    vecs[11] = '{0, 1'b0, 32'hFFC,  32'h0,         4'hF, 0, 1'b1, 32'hDEAD_BEEF};
    vecs[12] = '{0, 1'b1, 32'h20,   32'h7777_8888, 4'hF, 0, 1'b0, 32'h0};
    vecs[13] = '{0, 1'b1, 32'h30,   32'hA5A5_A5A5, 4'hF, 0, 1'b0, 32'h0};
    vecs[14] = '{0, 1'b1, 32'h34,   32'h1357_9BDF, 4'hF, 0, 1'b0, 32'h0};
    vecs[15] = '{1, 1'b1, 32'h0,    32'h600D_CAFE, 4'hF, 0, 1'b0, 32'h0};
    vecs[16] = '{1, 1'b0, 32'h0,    32'h0,         4'hF, 5, 1'b1, 32'h600D_CAFE};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      stb[d] = 1'b0; we[d] = 1'b0; adr[d] = '0; dat[d] = '0; sel[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check(ack[d] === 1'b0, $sformatf("reset_ack[%0d]", d), 32'(ack[d]), 32'd0);
      check(rdat[d] === 32'h0, $sformatf("reset_dat[%0d]", d), rdat[d], 32'h0);
    end

    for (int i = 0; i < NV; i++)
      txn(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].s, vecs[i].hold,
          vecs[i].chk, vecs[i].exp, i);

    // Abort in WAIT: strobe held for the accept edge only.
    @(posedge clk); #1;
    stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h20; dat[0] = 32'h5555_5555; sel[0] = 4'hF;
    @(posedge clk); #1;
    stb[0] = 1'b0;
    ok = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[0] !== 1'b0) ok = 1'b0;
    end
    check(ok, "abort_no_ack", 32'(ok), 32'd1);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b1, 32'h7777_8888, 100);

    // Reset while in WAIT: uncommitted write is lost.
    @(posedge clk); #1;
    stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h34; dat[0] = 32'hFFFF_FFFF; sel[0] = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    stb[0] = 1'b0;
    check(ack[0] === 1'b0, "rst_wait_ack", 32'(ack[0]), 32'd0);
    txn(0, 1'b0, 32'h34, 32'h0, 4'hF, 0, 1'b1, 32'h1357_9BDF, 101);

    // Reset while in ACK: outputs clear, committed write persists.
    @(posedge clk); #1;
    stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h30; sel[0] = 4'hF;
    n = 0;
    while (!ack[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(n == 3, "rst_ack_latency", 32'(n), 32'd3);
    check(rdat[0] === 32'hA5A5_A5A5, "rst_ack_pre_dat", rdat[0], 32'hA5A5_A5A5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    stb[0] = 1'b0;
    check(ack[0] === 1'b0, "rst_ack_ack", 32'(ack[0]), 32'd0);
    check(rdat[0] === 32'h0, "rst_ack_dat", rdat[0], 32'h0);
    txn(0, 1'b0, 32'h30, 32'h0, 4'hF, 0, 1'b1, 32'hA5A5_A5A5, 102);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
